// File: rtl/imem_arb.sv
// Instruction-memory arbiter: fetch port and loader port share one 4K-word SRAM window.
// Build option IMEM_ARB_RR_EN: round-robin conflict resolution (default: loader wins).
module imem_arb (
    input  logic        clk,
    input  logic        reset,
    // fetch port
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_err,
    // loader port
    input  logic        l_req,
    input  logic        l_we,
    input  logic        l_lock,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    output logic        l_err,
    // memory port
    output logic        m_en,
    output logic        m_we,
    output logic [11:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    typedef enum logic {ST_ARB, ST_LOCK} state_t;

    state_t      r_state;
    logic        r_f_rvalid, r_f_err, r_f_rd;
    logic        r_l_rvalid, r_l_err, r_l_rd;
    logic        w_f_gnt, w_l_gnt, w_ok, w_pick_f;
    logic [31:0] w_addr;

    function automatic logic in_window(input logic [31:0] a);
        return (a >= 32'h0000_3000) && (a <= 32'h0000_6FFF) && (a[1:0] == 2'b00);
    endfunction

`ifdef IMEM_ARB_RR_EN
    logic r_fav_f;
    assign w_pick_f = r_fav_f;
`else
    assign w_pick_f = 1'b0;
`endif

    always_comb begin
        w_f_gnt = (r_state == ST_ARB) && f_req && (!l_req || w_pick_f);
        w_l_gnt = l_req && ((r_state == ST_LOCK) || !f_req || !w_pick_f);
        w_addr  = w_l_gnt ? l_addr : f_addr;
        w_ok    = in_window(w_addr);
    end

    assign f_gnt   = w_f_gnt;
    assign l_gnt   = w_l_gnt;
    assign m_en    = (w_f_gnt || w_l_gnt) && w_ok;
    assign m_we    = m_en && w_l_gnt && l_we;
    assign m_addr  = w_addr[13:2] - 12'hC00;
    assign m_wdata = w_l_gnt ? l_wdata : 32'h0;

    // SRAM data only lands in the response cycle, so rdata is a registered gate on m_rdata.
    assign f_rvalid = r_f_rvalid;
    assign f_err    = r_f_err;
    assign f_rdata  = r_f_rd ? m_rdata : 32'h0;
    assign l_rvalid = r_l_rvalid;
    assign l_err    = r_l_err;
    assign l_rdata  = r_l_rd ? m_rdata : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_ARB;
            r_f_rvalid <= 1'b0;
            r_f_err    <= 1'b0;
            r_f_rd     <= 1'b0;
            r_l_rvalid <= 1'b0;
            r_l_err    <= 1'b0;
            r_l_rd     <= 1'b0;
`ifdef IMEM_ARB_RR_EN
            r_fav_f    <= 1'b1;
`endif
        end else begin
            r_f_rvalid <= w_f_gnt;
            r_f_err    <= w_f_gnt && !w_ok;
            r_f_rd     <= w_f_gnt && w_ok;
            r_l_rvalid <= w_l_gnt;
            r_l_err    <= w_l_gnt && !w_ok;
            r_l_rd     <= w_l_gnt && w_ok && !l_we;
            case (r_state)
                ST_ARB:  if (w_l_gnt && l_lock) r_state <= ST_LOCK;
                ST_LOCK: if (!l_lock)           r_state <= ST_ARB;
                default:                        r_state <= ST_ARB;
            endcase
`ifdef IMEM_ARB_RR_EN
            if ((r_state == ST_ARB) && f_req && l_req)
                r_fav_f <= !r_fav_f;
`endif
        end
    end

endmodule

// File: tb/tb_imem_arb.sv
// Randomized bench for imem_arb against a transaction-level reference model.
module tb_imem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, f_gnt, f_rvalid, f_err;
    logic [31:0] f_addr, f_rdata;
    logic        l_req, l_we, l_lock, l_gnt, l_rvalid, l_err;
    logic [31:0] l_addr, l_wdata, l_rdata;
    logic        m_en, m_we;
    logic [11:0] m_addr;
    logic [31:0] m_wdata, m_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_arb dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr),
        .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .l_err(l_err),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // SRAM behind the arbiter, self-initialising on its first clock
    logic [31:0] mem [0:4095];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'(i) * 32'h9E37_79B1;
            mem_init <= 1'b1;
        end else if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata     <= mem[m_addr];
        end
    end

    // reference model state
    logic [31:0] ref_mem [0:4095];
    bit          mdl_locked, mdl_fav_f;
    bit          pf_v, pf_e, pl_v, pl_e;
    logic [31:0] pf_d, pl_d;
    bit          last_fg, last_lg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        mdl_locked = 0; mdl_fav_f = 1;
        pf_v = 0; pl_v = 0; pf_e = 0; pl_e = 0; pf_d = 0; pl_d = 0;
    endtask

    // one clock: inputs are already applied; check at negedge, advance model, return at posedge+1
    task automatic cycle();
        bit ef, el, ok;
        logic [31:0] a;
        int idx;
        @(negedge clk);
        chk("f_rvalid", {31'b0, f_rvalid}, {31'b0, pf_v});
        chk("l_rvalid", {31'b0, l_rvalid}, {31'b0, pl_v});
        if (pf_v) begin
            chk("f_err", {31'b0, f_err}, {31'b0, pf_e});
            chk("f_rdata", f_rdata, pf_d);
        end
        if (pl_v) begin
            chk("l_err", {31'b0, l_err}, {31'b0, pl_e});
            chk("l_rdata", l_rdata, pl_d);
        end
        if (mdl_locked) begin
            ef = 0; el = l_req;
        end else if (f_req && l_req) begin
`ifdef IMEM_ARB_RR_EN
            ef = mdl_fav_f;
            mdl_fav_f = !mdl_fav_f;
`else
            ef = 0;
`endif
            el = !ef;
        end else begin
            ef = f_req; el = l_req;
        end
        a   = el ? l_addr : f_addr;
        ok  = (a >= 32'h3000) && (a < 32'h7000) && (a % 4 == 0);
        idx = ok ? int'((a - 32'h3000) / 4) : 0;
        chk("f_gnt", {31'b0, f_gnt}, {31'b0, ef});
        chk("l_gnt", {31'b0, l_gnt}, {31'b0, el});
        chk("m_en", {31'b0, m_en}, {31'b0, (ef || el) && ok});
        if ((ef || el) && ok) begin
            chk("m_addr", {20'b0, m_addr}, idx);
            chk("m_we", {31'b0, m_we}, {31'b0, el && l_we});
            if (el && l_we) chk("m_wdata", m_wdata, l_wdata);
        end
        pf_v = ef; pf_e = !ok;
        pf_d = (ef && ok) ? ref_mem[idx] : 32'h0;
        pl_v = el; pl_e = !ok;
        pl_d = (el && ok && !l_we) ? ref_mem[idx] : 32'h0;
        if (el && ok && l_we) ref_mem[idx] = l_wdata;
        mdl_locked = mdl_locked ? l_lock : (el && l_lock);
        last_fg = ef; last_lg = el;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] raddr();
        case ($urandom % 8)
            0: return 32'h7000;
            1: return 32'h2FFC;
            2: return 32'h3000 + 4 * ($urandom % 4096) + 1 + ($urandom % 3);
            3: return 32'h3000;
            4: return 32'h6FFC;
            default: return 32'h3000 + 4 * ($urandom % 4096);
        endcase
    endfunction

    task automatic idle_inputs();
        f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_lock = 0; l_addr = 0; l_wdata = 0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'(i) * 32'h9E37_79B1;
        idle_inputs();
        mdl_reset();
        reset = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_f_rvalid", {31'b0, f_rvalid}, 32'h0);
        chk("rst_l_rvalid", {31'b0, l_rvalid}, 32'h0);
        chk("rst_f_rdata", f_rdata, 32'h0);
        chk("rst_l_err", {31'b0, l_err}, 32'h0);
        @(posedge clk); #1;
        reset = 1;

        // fetch read at 0x3004
        f_req = 1; f_addr = 32'h3004; #1;
        chk("rd_maddr", {20'b0, m_addr}, 32'h001);
        cycle();
        f_req = 0;
        cycle();

        // loader write at 0x3FFC then read it back
        l_req = 1; l_we = 1; l_addr = 32'h3FFC; l_wdata = 32'h1234_5678; #1;
        chk("wr_maddr", {20'b0, m_addr}, 32'h3FF);
        chk("wr_mwdata", m_wdata, 32'h1234_5678);
        cycle();
        l_we = 0;
        cycle();
        l_req = 0;
        cycle();

        // out-of-window and misaligned fetches
        f_req = 1; f_addr = 32'h7000;
        cycle();
        f_addr = 32'h3002;
        cycle();
        f_req = 0;
        cycle();

        // four conflicting cycles
        f_req = 1; f_addr = 32'h3100; l_req = 1; l_addr = 32'h3200;
        repeat (4) cycle();
        idle_inputs();
        cycle();

        // lock ownership: fetch is starved until l_lock drops
        l_req = 1; l_lock = 1; l_addr = 32'h3300;
        cycle();
        l_req = 0; f_req = 1; f_addr = 32'h3400;
        repeat (3) cycle();
        l_lock = 0;
        cycle();
        cycle();
        f_req = 0;
        cycle();

        // reset in the cycle after a grant drops the response
        f_req = 1; f_addr = 32'h3008;
        cycle();
        f_req = 0;
        reset = 0; #1;
        chk("rst_drop_rvalid", {31'b0, f_rvalid}, 32'h0);
        mdl_reset();
        repeat (2) @(posedge clk);
        #1; reset = 1;
        cycle();
        cycle();

        // randomized traffic; an ungranted request is held unchanged
        last_fg = 1; last_lg = 1;
        for (int n = 0; n < 2000; n++) begin
            if (!f_req || last_fg) begin
                f_req  = ($urandom % 3) != 0;
                f_addr = raddr();
            end
            if (!l_req || last_lg) begin
                l_req   = ($urandom % 2) != 0;
                l_we    = ($urandom % 2) != 0;
                l_lock  = ($urandom % 6) == 0;
                l_addr  = raddr();
                l_wdata = $urandom;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- f_req  in  1  fetch request (read-only)
- f_addr  in  32  fetch byte address
- f_gnt  out  1  fetch granted this cycle
- f_rvalid  out  1  fetch response valid
- f_rdata  out  32  fetch read data
- f_err  out  1  fetch response error (qualifies f_rvalid)
- l_req  in  1  loader request
- l_we  in  1  loader write enable
- l_lock  in  1  loader requests exclusive ownership
- l_addr  in  32  loader byte address
- l_wdata  in  32  loader write data
- l_gnt, l_rvalid, l_err  out  1  loader grant / response valid / response error
- l_rdata  out  32  loader read data
- m_en, m_we  out  1  memory access enable / write enable
- m_addr  out  12  memory word index
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid one cycle after m_en

Function
REQ-002 Valid window SHALL be byte addresses 0x0000_3000..0x0000_6FFF, word-aligned; m_addr SHALL equal addr[13:2] - 12'hC00.
REQ-003 The block SHALL implement a two-state FSM: ARB and LOCK.
REQ-004 In ARB, at most one requester SHALL be granted per cycle; gnt, m_en, m_we, m_addr, m_wdata are combinational in the grant cycle.
REQ-005 In ARB with only one request asserted, that requester SHALL be granted.
REQ-006 On simultaneous f_req and l_req in ARB, the winner SHALL be chosen per REQ-019.
REQ-007 A granted valid access SHALL assert m_en; m_we SHALL equal l_we for loader and 0 for fetch.
REQ-008 An out-of-window or misaligned request SHALL still be granted, SHALL NOT assert m_en, and SHALL produce err=1 with rdata=0 in the response cycle.
REQ-009 Response SHALL arrive exactly one cycle after grant: rvalid=1 to the granted requester only; rdata=m_rdata on reads; rdata=0 on writes.
REQ-010 Back-to-back grants SHALL be allowed; sustained throughput SHALL be one access per cycle.
REQ-011 Ungranted requesters SHALL hold req/addr/data stable until granted; the block SHALL NOT buffer requests.
REQ-012 A loader grant with l_lock=1 SHALL move the FSM ARB->LOCK at the next edge.
REQ-013 In LOCK, only loader requests SHALL be granted; f_gnt SHALL stay 0 regardless of f_req.
REQ-014 In LOCK, l_lock=0 sampled at an edge SHALL return the FSM to ARB; a grant in that same cycle is still served.
REQ-015 In LOCK with l_req=0, no memory access SHALL occur; LOCK SHALL persist while l_lock=1.
REQ-016 A pending response SHALL complete even if the FSM changes state in the same cycle.

Reset
REQ-017 Asserting reset (low) SHALL immediately force FSM=ARB, clear response-pending flags, set round-robin pointer to favour fetch, and drive every registered output (f_rvalid, l_rvalid, f_err, l_err, f_rdata, l_rdata) to 0.
REQ-018 Reset mid-access SHALL drop the in-flight response; no rvalid SHALL appear after release for a pre-reset grant; first grant possible in first cycle after release.

Configuration
REQ-019 Macro IMEM_ARB_RR_EN: defined -> conflicts in ARB resolved round-robin, pointer toggles to the other requester after each conflicting grant, fetch wins first after reset; undefined -> loader always wins conflicts (fixed priority), no pointer state.

Verification
REQ-020 f_req=1, f_addr=0x3004, m_rdata=0xDEADBEEF -> cycle 0: f_gnt=1, m_en=1, m_addr=0x001; cycle 1: f_rvalid=1, f_rdata=0xDEADBEEF, f_err=0.
REQ-021 l_req=1, l_we=1, l_addr=0x3FFC, l_wdata=0x12345678 -> m_we=1, m_addr=0x3FF, m_wdata=0x12345678; next cycle l_rvalid=1, l_rdata=0.
REQ-022 f_addr=0x7000, then f_addr=0x3002 -> f_gnt=1, m_en=0; response f_rvalid=1, f_err=1, f_rdata=0 for each.
REQ-023 Both request for 4 cycles -> RR_EN: grants F,L,F,L; without: L,L,L,L and f_gnt=0.
REQ-024 Loader grant with l_lock=1, then f_req=1 for 3 cycles while l_lock=1 -> f_gnt=0; l_lock=0 -> fetch granted next cycle.
REQ-025 reset low in the cycle after grant -> f_rvalid=0 immediately and stays 0 after release.
